// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port RAM arbiter: FSM states, owner
// encoding and default bus widths reused by the CPU and RAM wrappers.
package mem_port_arbiter_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data ports, with a starvation counter
// that forces an instruction grant after STARVE_LIMIT consecutive data wins.
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  logic   arb_i,
  output logic   grant_o,
  output owner_e owner_o
);

  logic [3:0] starve_q, starve_d;
  logic       d_win;

  always_comb begin
    d_win    = d_req_i && (!i_req_i || (starve_q < 4'(STARVE_LIMIT)));
    grant_o  = d_win || i_req_i;
    owner_o  = d_win ? OWN_D : OWN_I;
    starve_d = starve_q;
    if (arb_i) begin
      // A data win with i_req pending implies starve_q < limit, so the
      // increment saturates at STARVE_LIMIT without an explicit clamp.
      if (d_win && i_req_i) starve_d = starve_q + 4'd1;
      else                  starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// load/store port: arbitrate, issue, wait out read latency, acknowledge.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d, gnt_owner;
  logic          grant;
  logic [1:0]    lat_q, lat_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req_i(i_req),
    .d_req_i(d_req),
    .arb_i  (state_q == IDLE),
    .grant_o(grant),
    .owner_o(gnt_owner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          owner_d = gnt_owner;
          if (gnt_owner == OWN_D) begin
            m_addr_d  = d_addr;
            m_we_d    = d_we;
            m_wdata_d = d_wdata;
          end else begin
            m_addr_d  = i_addr;
            m_we_d    = 1'b0;
            m_wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (m_we_q) begin
          state_d = ACK;
        end else begin
          state_d = WAIT;
          lat_d   = 2'(READ_LAT - 1);
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = ACK;
          if (owner_q == OWN_D) d_rdata_d = m_rdata;
          else                  i_rdata_d = m_rdata;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      lat_q     <= '0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_q     <= lat_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_en    = (state_q == ISSUE);
  assign m_we    = m_en && m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = (state_q == ACK) && (owner_q == OWN_I);
  assign d_ack   = (state_q == ACK) && (owner_q == OWN_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (READ_LAT 2, 1, 4) checked each
// cycle against a transaction-level model, plus directed literal checks.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req   [3];
  logic        d_req   [3];
  logic        d_we    [3];
  logic [15:0] i_addr  [3];
  logic [15:0] d_addr  [3];
  logic [15:0] d_wdata [3];
  logic        i_ack   [3];
  logic        d_ack   [3];
  logic        m_en    [3];
  logic        m_we    [3];
  logic        busy    [3];
  logic [15:0] i_rdata [3];
  logic [15:0] d_rdata [3];
  logic [15:0] m_addr  [3];
  logic [15:0] m_wdata [3];
  logic [15:0] m_rdata [3];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int g);
    if (g == 0) return 2;
    if (g == 1) return 1;
    return 4;
  endfunction

  function automatic logic [15:0] init_val(input int a);
    if (a == 32'h0100) return 16'h1234;
    return 16'(a * 7 + 3) ^ 16'hC3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    mem_port_arbiter #(
      .AW(16), .DW(16), .READ_LAT(LAT), .STARVE_LIMIT(3)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g]), .busy(busy[g])
    );
  end

  // RAM model: writes land at the m_en edge, reads appear READ_LAT edges later
  logic [15:0] ram_wr [int];
  logic [15:0] pipe [3][4];
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (m_en[g]) begin
        if (m_we[g]) ram_wr[g * 65536 + int'(m_addr[g])] = m_wdata[g];
        else pipe[g][0] <= ram_wr.exists(g * 65536 + int'(m_addr[g])) ?
                           ram_wr[g * 65536 + int'(m_addr[g])] : init_val(int'(m_addr[g]));
      end
      for (int i = 1; i < 4; i++) pipe[g][i] <= pipe[g][i-1];
    end
  end
  assign m_rdata[0] = pipe[0][1];
  assign m_rdata[1] = pipe[1][0];
  assign m_rdata[2] = pipe[2][3];

  // Transaction model: k = cycles since grant (0 = idle), ack when k == tot
  int          k   [3];
  int          tot [3];
  int          stv [3];
  bit          own_d [3];
  bit          mwe [3];
  logic [15:0] maddr [3];
  logic [15:0] mwd [3];
  logic [15:0] e_ird [3];
  logic [15:0] e_drd [3];
  logic [15:0] sh_wr [int];
  bit          model_ok = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit gd;
    logic [15:0] v;
    if (!rst_n) begin
      model_ok = 1'b1;
      for (int g = 0; g < 3; g++) begin
        k[g] = 0; stv[g] = 0; e_ird[g] = '0; e_drd[g] = '0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (k[g] == 0) begin
          gd = d_req[g] && (!i_req[g] || stv[g] < 3);
          if (gd) begin
            own_d[g] = 1'b1; mwe[g] = d_we[g]; maddr[g] = d_addr[g]; mwd[g] = d_wdata[g];
            stv[g] = i_req[g] ? stv[g] + 1 : 0;
          end else if (i_req[g]) begin
            own_d[g] = 1'b0; mwe[g] = 1'b0; maddr[g] = i_addr[g];
            stv[g] = 0;
          end else begin
            stv[g] = 0;
          end
          if (gd || i_req[g]) begin
            k[g] = 1;
            tot[g] = mwe[g] ? 2 : 2 + lat_of(g);
            if (mwe[g]) sh_wr[g * 65536 + int'(maddr[g])] = mwd[g];
          end
        end else if (k[g] == tot[g]) begin
          k[g] = 0;
        end else begin
          k[g]++;
          if (k[g] == tot[g] && !mwe[g]) begin
            v = sh_wr.exists(g * 65536 + int'(maddr[g])) ?
                sh_wr[g * 65536 + int'(maddr[g])] : init_val(int'(maddr[g]));
            if (own_d[g]) e_drd[g] = v;
            else          e_ird[g] = v;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("busy[%0d]", g), 32'(busy[g]), 32'(k[g] != 0));
        chk($sformatf("m_en[%0d]", g), 32'(m_en[g]), 32'(k[g] == 1));
        chk($sformatf("m_we[%0d]", g), 32'(m_we[g]), 32'(k[g] == 1 && mwe[g]));
        chk($sformatf("i_ack[%0d]", g), 32'(i_ack[g]), 32'(k[g] != 0 && k[g] == tot[g] && !own_d[g]));
        chk($sformatf("d_ack[%0d]", g), 32'(d_ack[g]), 32'(k[g] != 0 && k[g] == tot[g] && own_d[g]));
        chk($sformatf("i_rdata[%0d]", g), 32'(i_rdata[g]), 32'(e_ird[g]));
        chk($sformatf("d_rdata[%0d]", g), 32'(d_rdata[g]), 32'(e_drd[g]));
        if (k[g] == 1) begin
          chk($sformatf("m_addr[%0d]", g), 32'(m_addr[g]), 32'(maddr[g]));
          if (mwe[g]) chk($sformatf("m_wdata[%0d]", g), 32'(m_wdata[g]), 32'(mwd[g]));
        end
      end
    end
  end

  bit ack_log[$];

  // Called just after a negedge; returns at the negedge where the ack is seen.
  task automatic req_txn(input int g, input bit port_d, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input bit chg, input logic [15:0] addr2,
                         output int lat, output logic [15:0] rd);
    bit got = 1'b0;
    lat = 0;
    rd  = '0;
    if (port_d) begin
      d_req[g] = 1'b1; d_we[g] = we; d_addr[g] = addr; d_wdata[g] = wdata;
    end else begin
      i_req[g] = 1'b1; i_addr[g] = addr;
    end
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (chg && lat == 1) d_addr[g] = addr2;
      if (port_d ? d_ack[g] : i_ack[g]) got = 1'b1;
    end
    chk($sformatf("ack_seen[%0d]", g), 32'(got), 32'd1);
    rd = port_d ? d_rdata[g] : i_rdata[g];
    ack_log.push_back(port_d);
    if (port_d) d_req[g] = 1'b0;
    else        i_req[g] = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_i_ack"},   32'(i_ack[0]),   32'd0);
    chk({tag, "_d_ack"},   32'(d_ack[0]),   32'd0);
    chk({tag, "_m_en"},    32'(m_en[0]),    32'd0);
    chk({tag, "_m_we"},    32'(m_we[0]),    32'd0);
    chk({tag, "_busy"},    32'(busy[0]),    32'd0);
    chk({tag, "_m_addr"},  32'(m_addr[0]),  32'd0);
    chk({tag, "_m_wdata"}, 32'(m_wdata[0]), 32'd0);
    chk({tag, "_i_rdata"}, 32'(i_rdata[0]), 32'd0);
    chk({tag, "_d_rdata"}, 32'(d_rdata[0]), 32'd0);
  endtask

  initial begin
    int          lat;
    int          nack;
    logic [15:0] rd;
    bit          exp_order [8];
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      i_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 1'b0;
      i_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;
    end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    req_txn(0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, '0, lat, rd);
    chk("write_lat", 32'(lat), 32'd2);
    @(negedge clk);
    req_txn(0, 1'b1, 1'b0, 16'h0040, '0, 1'b0, '0, lat, rd);
    chk("read_lat", 32'(lat), 32'd4);
    chk("read_data", 32'(rd), 32'hBEEF);
    @(negedge clk);
    req_txn(0, 1'b0, 1'b0, 16'h0100, '0, 1'b0, '0, lat, rd);
    chk("fetch_lat", 32'(lat), 32'd4);
    chk("fetch_data", 32'(rd), 32'h1234);

    // Both ports held continuously: data wins three times, then fetch once
    @(negedge clk);
    ack_log.delete();
    fork
      begin
        int l; logic [15:0] r;
        for (int n = 0; n < 6; n++)
          req_txn(0, 1'b1, 1'b0, 16'(16'h0200 + n), '0, 1'b0, '0, l, r);
      end
      begin
        int l; logic [15:0] r;
        for (int n = 0; n < 2; n++)
          req_txn(0, 1'b0, 1'b0, 16'h0100, '0, 1'b0, '0, l, r);
      end
    join
    chk("order_len", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++)
      chk($sformatf("order[%0d]", i), 32'(ack_log[i]), 32'(exp_order[i]));

    @(negedge clk);
    req_txn(1, 1'b1, 1'b0, 16'h0002, '0, 1'b0, '0, lat, rd);
    chk("lat1_lat", 32'(lat), 32'd3);
    chk("lat1_data", 32'(rd), 32'hC3D2);
    @(negedge clk);
    req_txn(2, 1'b1, 1'b0, 16'h0002, '0, 1'b0, '0, lat, rd);
    chk("lat4_lat", 32'(lat), 32'd6);
    chk("lat4_data", 32'(rd), 32'hC3D2);

    // Reset while the read sits in its latency wait
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0040;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    d_req[0] = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nack = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_ack[0] || i_ack[0]) nack++;
    end
    chk("no_ack_after_reset", 32'(nack), 32'd0);
    req_txn(0, 1'b1, 1'b0, 16'h0040, '0, 1'b0, '0, lat, rd);
    chk("post_reset_lat", 32'(lat), 32'd4);
    chk("post_reset_data", 32'(rd), 32'hBEEF);

    // Address changed during ISSUE must not affect the access
    @(negedge clk);
    req_txn(0, 1'b1, 1'b0, 16'h0010, '0, 1'b1, 16'h0020, lat, rd);
    chk("unstable_lat", 32'(lat), 32'd4);
    chk("unstable_data", 32'(rd), 32'hC3B0);
    nack = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_ack[0]) nack++;
    end
    chk("unstable_single_ack", 32'(nack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the CPU instruction-fetch port and the load/store data port, replacing dual-ported memory access.
- Arbitrates requests, sequences each access (issue, read-latency wait, acknowledge) and returns read data to the winning requester.
- Data port has priority; a starvation counter guarantees instruction fetch progress.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- READ_LAT, 1, RAM read latency in cycles from the m_en sampling edge to m_rdata valid. Legal range 1..4.
- STARVE_LIMIT, 3, consecutive data grants taken while i_req is pending before the instruction port is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata valid in that cycle.
- i_rdata  out  DW  fetched word, registered, holds until next i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle pulse; write completed or d_rdata valid.
- d_rdata  out  DW  read word, registered, holds until next read d_ack.
- m_en  out  1  RAM enable, high exactly one cycle per access.
- m_we  out  1  RAM write enable, qualified by m_en.
- m_addr  out  AW  RAM address.
- m_wdata  out  DW  RAM write data.
- m_rdata  in  DW  RAM read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, starve_cnt=0; all outputs 0 (i_ack, d_ack, m_en, m_we, busy, m_addr, m_wdata, i_rdata, d_rdata).
- Reset asserted mid-transaction aborts it: no ack is issued and m_en drops immediately. Requesters re-request after reset.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE, arbitration on each edge:
  - If d_req and (!i_req or starve_cnt<STARVE_LIMIT), grant D.
  - Else if i_req, grant I.
  - On a grant, register owner, m_addr, m_we (d_we for D, 0 for I) and m_wdata; go to ISSUE.
- starve_cnt:
  - Increments on a D grant while i_req=1.
  - Clears on any I grant, and whenever i_req=0 at an arbitration edge.
  - Saturates at STARVE_LIMIT.
- ISSUE: m_en=1 for this cycle only.
  - Write: next state ACK.
  - Read: next state WAIT, with the latency counter loaded to READ_LAT-1.
- WAIT: counter decrements each cycle. On the edge where it reads 0, capture m_rdata into the owner's rdata register and go to ACK.
  - With READ_LAT=1, WAIT lasts one cycle and captures at the first edge after the ISSUE cycle.
- ACK: owner's ack=1 for one cycle; next state IDLE.
  - No arbitration is performed during ACK. The requester must drop req, or present a new request, by the end of ACK.
- Latency, grant edge to ack assertion:
  - Write: 2 cycles.
  - Read: 2+READ_LAT cycles.
  - Minimum spacing between back-to-back grants: write 3 cycles, read 3+READ_LAT cycles.
- Simultaneous requests: D wins until starve_cnt reaches STARVE_LIMIT; then I wins once.
- Request changes after grant are ignored, because addr, we and wdata are latched at the grant edge.
- Exactly one ack per granted access. i_ack and d_ack are never high together.
- The instruction port never writes (m_we=0 on I grants).
- Widths: addresses and data pass unchanged. Latency counter is 2 bits; starve_cnt is 4 bits.

Decomposition:
- Shared package/header mem_defs:
  - Localparams for FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3).
  - Owner encoding (OWN_I=0, OWN_D=1).
  - Default AW/DW (16) for reuse by the CPU and RAM.
- One sub-module, mem_arb_prio: combinational grant decision plus the starve_cnt register.
  - Inputs: i_req, d_req, arbitrate strobe.
  - Output: grant/owner.
  - The FSM, latency counter and data registers stay in mem_port_arbiter.

Test Plan (READ_LAT=2, STARVE_LIMIT=3 unless noted):
- Single write then read: d_req, d_we=1, d_addr=0x0040, d_wdata=0xBEEF.
  - Expect m_en/m_we high one cycle with m_addr=0x0040 and d_ack 2 cycles after grant.
  - Then a read of 0x0040 gives d_rdata=0xBEEF with d_ack 4 cycles after grant.
- Instruction fetch: i_req, i_addr=0x0100, RAM preloaded with 0x1234 → i_ack 4 cycles after grant, i_rdata=0x1234, m_we=0 throughout.
- Contention/starvation: i_req and d_req held continuously.
  - Expected grant order: D,D,D,I,D,D,D,I.
  - starve_cnt returns to 0 after each I grant.
  - Acks never overlap.
- Latency sweep READ_LAT=1 and READ_LAT=4: read at 0x0002 → ack at 3 and 6 cycles after grant respectively, with correct data.
- Reset mid-read: assert rst_n=0 during WAIT.
  - Expect all outputs 0 asynchronously, no ack after release, FSM in IDLE.
  - The next request completes normally.
- Request instability: change d_addr from 0x0010 to 0x0020 during ISSUE → access uses 0x0010, and only one d_ack is produced.
